logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares a single `logic_unit` instance among `NUM_REQ` requesters. It arbitrates per cycle, drives the shared operands and `logic_op_t` opcode, and tracks the in-flight request through the unit's one-cycle registered output. Results are returned on a tagged valid/ready response port through a 2-entry response FIFO. The block sits in the execute stage between the issue slots and the shared `logic_unit`.

## Interface
- `WIDTH`, 64, operand/result width; must equal the shared unit's `WIDTH`
- `NUM_REQ`, 4, number of requesters, 2..16
- `ID_W`, `$clog2(NUM_REQ)`, requester index width

- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero
- `req_a`, `req_b`, `req_c`  in  NUM_REQ×WIDTH  per-requester operands
- `req_op`  in  NUM_REQ×logic_op_t  per-requester opcode
- `lu_a`, `lu_b`, `lu_c`  out  WIDTH  to shared unit; combinational from the granted requester
- `lu_op`  out  logic_op_t  to shared unit
- `lu_out`  in  WIDTH  shared unit's registered `out`
- `rsp_valid`  out  1  response valid (FIFO head)
- `rsp_ready`  in  1  response consumer accept
- `rsp_id`  out  ID_W  index of the originating requester
- `rsp_data`  out  WIDTH  result

## Operation
- **Issue condition:** `can_issue = (fifo_cnt + s1_valid - pop) < 2`, where `pop = rsp_valid & rsp_ready`. This guarantees every in-flight result has a FIFO slot, because `lu_out` cannot be stalled.
- **Grant:** when `can_issue` and any `req_valid` is set, exactly one requester is granted. `req_ready[g] = 1` for the granted requester only. Otherwise `req_ready = '0`.
- **Acceptance:** a request is accepted when `req_valid[g] & req_ready[g]`. `lu_*` carry that requester's operands and opcode in the same cycle.
- **Idle drive:** with no grant, `lu_a`, `lu_b` and `lu_c` are `'0` and `lu_op` is `AND`, so no toggling.
- **Stage s1:** registers `s1_valid <= accept` and `s1_id <= g`. In the next cycle, `lu_out` holds the result.
- **FIFO write:** when `s1_valid`, `{s1_id, lu_out}` is pushed into the 2-entry FIFO.
- **FIFO pop:** on `rsp_valid & rsp_ready`. Push and pop in the same cycle are allowed at any count, including full (the pop frees the slot first).
- **Arbiter pointer:** `last_grant` updates only on accept. In round-robin mode the search starts at `last_grant+1`, modulo `NUM_REQ`, and wraps.
- **Requester obligation:** requesters hold `req_*` stable while valid and not ready. The arbiter does not need to re-grant the same requester.
- **Response order:** responses return in acceptance order.
- **Reset:** `rst` high clears everything, including mid-operation: `s1_valid=0`, FIFO empty, `last_grant=NUM_REQ-1`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `req_ready='0`. An in-flight result is discarded and never appears on `rsp`.

## Timing
- **Latency:** accept at cycle T → `lu_out` valid in T+1 → pushed at the end of T+1 → `rsp_valid` in T+2, with an empty FIFO.
- **Throughput:** 1 accept/cycle while `rsp_ready` stays high.
- **Backpressure:** with `rsp_ready` low, at most 2 accepts occur before `req_ready` deasserts. Issue resumes in the same cycle `rsp_ready` pops, via the `- pop` term.
- **Combinational paths:** `req_ready` depends combinationally on `req_valid` and `rsp_ready`. No combinational path exists from `lu_out` to any output.
- **Registered outputs:** `rsp_*` are FIFO-register outputs and are stable while `rsp_valid & !rsp_ready`.

## Configuration
- **`LU_ARB_RR_EN` defined:** round-robin arbitration starting at `last_grant+1`.
- **`LU_ARB_RR_EN` undefined:** fixed priority, lowest index wins. `last_grant` is not implemented, and starvation of high indices is permitted.

## Test plan
- **Single request:** reset, then req0 `{a=0xF0, b=0x3C, op=AND}` held one cycle, `rsp_ready=1` → `rsp_valid` 2 cycles later with `rsp_id=0` and `rsp_data=0x30`.
- **Round-robin fairness (`LU_ARB_RR_EN` defined):** all 4 requesters valid continuously with `rsp_ready=1` → grants 0,1,2,3,0,… one per cycle. `rsp_id` follows the same sequence 2 cycles delayed.
- **Fixed priority (`LU_ARB_RR_EN` undefined):** req0 and req2 valid continuously → req0 is granted every cycle and req2 never.
- **Backpressure:** `rsp_ready=0` with req1 valid (`op=XOR`, `a=5`, `b=3`) → exactly 2 accepts, then `req_ready=0`, `rsp_data=6` held stable. Raising `rsp_ready` pops one response and grants one request in the same cycle.
- **Reset mid-flight:** accept req3 (`op=MAX3`, `a=1`, `b=9`, `c=4`), assert `rst` the next cycle → no `rsp_valid` ever appears for that request, all outputs read 0, and the pointer restarts so req0 is granted first.
- **Three-operand op under full-throughput interleave:** `op=MAX3` with `a=-2`, `b=-7`, `c=-1` (signed) → `rsp_data=-1`. Interleaved with `EQ a=b=0xAA` → `rsp_data=1`, with order preserved.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Lets NUM_REQ issue slots share one registered logic_unit. Each cycle it
//   grants one requester, drives that requester's operands and opcode to the
//   unit, and tracks the in-flight op through s1. One cycle later the unit's
//   result goes into a 2-entry response FIFO, tagged with the requester index.
//
//   Build option: define LU_ARB_RR_EN for round-robin arbitration. When it is
//   undefined, arbitration is fixed priority and the lowest index wins.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_a/b/c, req_op   per-requester operands and opcode
//   lu_a/b/c, lu_op     to the shared unit (idle: zeros and AND)
//   lu_out              registered result from the shared unit
//   rsp_valid/ready     response handshake (FIFO head)
//   rsp_id, rsp_data    originating requester index and result

package logic_unit_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_EQ   = 3'd4,
    OP_MAX3 = 3'd5,
    OP_MIN3 = 3'd6,
    OP_MAJ  = 3'd7
  } logic_op_t;
endpackage

module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_c,
  input  logic_op_t [NUM_REQ-1:0]       req_op,
  output logic [WIDTH-1:0]              lu_a,
  output logic [WIDTH-1:0]              lu_b,
  output logic [WIDTH-1:0]              lu_c,
  output logic_op_t                     lu_op,
  input  logic [WIDTH-1:0]              lu_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [WIDTH-1:0]              rsp_data
);

  logic                  s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0][ID_W-1:0]  fifo_id_q, fifo_id_d;
  logic [1:0][WIDTH-1:0] fifo_data_q, fifo_data_d;

  logic            pop, push, can_issue, accept, gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [2:0]      occ;

`ifdef LU_ARB_RR_EN
  localparam int CW = ID_W + 1;  // holds last_grant + NUM_REQ without overflow
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0]   cand;
`endif

  // ---------------- grant selection ----------------
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
`ifdef LU_ARB_RR_EN
    cand = '0;
    // Search starts just after the last winner and wraps modulo NUM_REQ.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = CW'(last_grant_q) + CW'(i + 1);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[ID_W-1:0];
      end
    end
`else
    // Descending scan so the lowest valid index is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(i);
      end
    end
`endif
  end

  // ---------------- issue gating ----------------
  // lu_out cannot stall, so only issue when the result is sure of a FIFO
  // slot: entries held + one in flight - one leaving this cycle < 2.
  assign rsp_valid = (fifo_cnt_q != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = s1_valid_q;
  assign occ       = 3'(fifo_cnt_q) + 3'(s1_valid_q) - 3'(pop);
  assign can_issue = (occ < 3'd2) & ~rst;
  assign accept    = can_issue & gnt_found;

  // Operand mux; the idle value is a constant so the unit's inputs stay quiet.
  always_comb begin
    req_ready = '0;
    lu_a      = '0;
    lu_b      = '0;
    lu_c      = '0;
    lu_op     = OP_AND;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
      lu_a              = req_a[gnt_id];
      lu_b              = req_b[gnt_id];
      lu_c              = req_c[gnt_id];
      lu_op             = req_op[gnt_id];
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    s1_valid_d  = accept;
    s1_id_d     = accept ? gnt_id : s1_id_q;
    fifo_id_d   = fifo_id_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    // When full, wr_ptr == rd_ptr, so a push with a pop overwrites the head
    // that is leaving this cycle.
    if (push) begin
      fifo_id_d[wr_ptr_q]   = s1_id_q;
      fifo_data_d[wr_ptr_q] = lu_out;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
  end

`ifdef LU_ARB_RR_EN
  always_comb begin
    last_grant_d = accept ? gnt_id : last_grant_q;
  end
`endif

  // Response outputs come straight from the FIFO registers.
  assign rsp_id   = fifo_id_q[rd_ptr_q];
  assign rsp_data = fifo_data_q[rd_ptr_q];

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      fifo_cnt_q   <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_id_q    <= '0;
      fifo_data_q  <= '0;
`ifdef LU_ARB_RR_EN
      last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      fifo_cnt_q   <= fifo_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_id_q    <= fifo_id_d;
      fifo_data_q  <= fifo_data_d;
`ifdef LU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter. It includes a behavioural model of
// the shared registered logic_unit, so lu_out follows lu_* one clock later.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  localparam int WIDTH   = 64;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a, req_b, req_c;
  logic_op_t [NUM_REQ-1:0]       req_op;
  logic [WIDTH-1:0]              lu_a, lu_b, lu_c, lu_out;
  logic_op_t                     lu_op;
  logic                          rsp_valid, rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [WIDTH-1:0]              rsp_data;

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_op(req_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_c(lu_c), .lu_op(lu_op), .lu_out(lu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared unit model: one registered stage.
  function automatic logic [WIDTH-1:0] lu_f(input logic_op_t op,
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_EQ:   return {{(WIDTH-1){1'b0}}, a == b};
      OP_MAX3: begin
        m = a;
        if ($signed(b) > $signed(m)) m = b;
        if ($signed(c) > $signed(m)) m = c;
        return m;
      end
      OP_MIN3: begin
        m = a;
        if ($signed(b) < $signed(m)) m = b;
        if ($signed(c) < $signed(m)) m = c;
        return m;
      end
      default: return (a & b) | (a & c) | (b & c);
    endcase
  endfunction

  always_ff @(posedge clk) lu_out <= lu_f(lu_op, lu_a, lu_b, lu_c);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_req();
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i]  = '0;
      req_b[i]  = '0;
      req_c[i]  = '0;
      req_op[i] = OP_AND;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_req();
    cyc();
    rst = 1'b0;
  endtask

  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int accepts;
    int pops;
    int exp_rdy [5];
    rst       = 1'b1;
    rsp_ready = 1'b1;
    clr_req();

    // ---- reset state: requests present but reset holds everything off ----
    req_valid = 4'hF;
    cyc();
    smp();
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_id",    64'(rsp_id),    64'h0);
    chk("rst_rsp_data",  rsp_data,       64'h0);
    chk("rst_lu_a",      lu_a,           64'h0);
    cyc();
    rst = 1'b0;
    clr_req();

    // ---- single request: F0 & 3C = 30, response two cycles later ----
    req_valid[0] = 1'b1;
    req_a[0] = 64'hF0; req_b[0] = 64'h3C; req_op[0] = OP_AND;
    smp();
    chk("single_ready", 64'(req_ready), 64'h1);
    chk("single_lu_a",  lu_a, 64'hF0);
    chk("single_lu_b",  lu_b, 64'h3C);
    chk("single_rsp_t0", 64'(rsp_valid), 64'h0);
    cyc();
    clr_req();
    smp();
    chk("single_rsp_t1", 64'(rsp_valid), 64'h0);
    chk("idle_lu_op", 64'(lu_op), 64'(OP_AND));
    cyc();
    smp();
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_rsp_id",    64'(rsp_id),    64'h0);
    chk("single_rsp_data",  rsp_data,       64'h30);
    cyc();
    smp();
    chk("single_rsp_gone", 64'(rsp_valid), 64'h0);
    cyc();

`ifdef LU_ARB_RR_EN
    // ---- round robin: all valid, requester i returns i+1 ----
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = 64'(i + 1); req_op[i] = OP_OR;
    end
    for (int k = 0; k < 8; k++) begin
      smp();
      chk($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("rr_rsp_valid%0d", k), 64'(rsp_valid), 64'h1);
        chk($sformatf("rr_rsp_id%0d", k),    64'(rsp_id),    64'((k - 2) % 4));
        chk($sformatf("rr_rsp_data%0d", k),  rsp_data,       64'((k - 2) % 4 + 1));
      end
      cyc();
    end
`else
    // ---- fixed priority: req0 beats req2 every cycle ----
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    req_a[0] = 64'd1; req_op[0] = OP_OR;
    req_a[2] = 64'd3; req_op[2] = OP_OR;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk($sformatf("fp_grant%0d", k), 64'(req_ready), 64'h1);
      if (k >= 2) begin
        chk($sformatf("fp_rsp_id%0d", k),   64'(rsp_id), 64'h0);
        chk($sformatf("fp_rsp_data%0d", k), rsp_data,    64'h1);
      end
      cyc();
    end
`endif

    // ---- backpressure: 5 ^ 3 = 6, only two accepts with rsp_ready low ----
    do_reset();
    rsp_ready = 1'b0;
    req_valid[1] = 1'b1;
    req_a[1] = 64'd5; req_b[1] = 64'd3; req_op[1] = OP_XOR;
    accepts = 0;
    pops    = 0;
    exp_rdy = '{2, 2, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      smp();
      if (req_valid[1] && req_ready[1]) accepts++;
      chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'(exp_rdy[k]));
      if (k >= 2) begin
        chk($sformatf("bp_rsp_valid%0d", k), 64'(rsp_valid), 64'h1);
        chk($sformatf("bp_rsp_id%0d", k),    64'(rsp_id),    64'h1);
        chk($sformatf("bp_rsp_data%0d", k),  rsp_data,       64'h6);
      end
      cyc();
    end
    chk("bp_accepts", 64'(accepts), 64'h2);
    rsp_ready = 1'b1;
    smp();
    chk("bp_resume_ready", 64'(req_ready), 64'h2);
    chk("bp_resume_rsp",   64'(rsp_valid), 64'h1);
    cyc();
    clr_req();
    for (int k = 0; k < 4; k++) begin
      smp();
      if (rsp_valid) begin
        pops++;
        chk($sformatf("bp_drain_data%0d", k), rsp_data, 64'h6);
      end
      cyc();
    end
    chk("bp_drain_pops", 64'(pops), 64'h2);

    // ---- reset while a MAX3 is in flight ----
    do_reset();
    rsp_ready = 1'b1;
    req_valid[3] = 1'b1;
    req_a[3] = 64'd1; req_b[3] = 64'd9; req_c[3] = 64'd4; req_op[3] = OP_MAX3;
    smp();
    chk("mid_grant3", 64'(req_ready), 64'h8);
    cyc();
    rst = 1'b1;
    clr_req();
    smp();
    chk("mid_rst_ready",     64'(req_ready), 64'h0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_rsp_id",    64'(rsp_id),    64'h0);
    chk("mid_rst_rsp_data",  rsp_data,       64'h0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("mid_no_rsp%0d", k), 64'(rsp_valid), 64'h0);
      cyc();
    end
    req_valid = 4'b1001;
    req_a[0] = 64'd7; req_b[0] = 64'hFF; req_op[0] = OP_AND;
    req_a[3] = 64'd2; req_b[3] = 64'hFF; req_op[3] = OP_AND;
    smp();
    chk("mid_restart_grant", 64'(req_ready), 64'h1);
    cyc();
    clr_req();
    smp();
    cyc();
    smp();
    chk("mid_restart_rsp_id",   64'(rsp_id), 64'h0);
    chk("mid_restart_rsp_data", rsp_data,    64'h7);
    cyc();

    // ---- interleaved MAX3 (req0) and EQ (req1) at full rate ----
    do_reset();
    rsp_ready = 1'b1;
    req_a[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    req_b[0] = 64'hFFFF_FFFF_FFFF_FFF9;
    req_c[0] = M1;
    req_op[0] = OP_MAX3;
    req_a[1] = 64'hAA; req_b[1] = 64'hAA; req_op[1] = OP_EQ;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? ((k % 2 == 1) ? 4'b0010 : 4'b0001) : 4'b0000;
      smp();
      if (k < 6)
        chk($sformatf("il_grant%0d", k), 64'(req_ready), (k % 2 == 1) ? 64'h2 : 64'h1);
      if (k == 0) chk("il_lu_c", lu_c, M1);
      if (k >= 2) begin
        chk($sformatf("il_rsp_valid%0d", k), 64'(rsp_valid), 64'h1);
        chk($sformatf("il_rsp_id%0d", k),    64'(rsp_id),    64'((k - 2) % 2));
        chk($sformatf("il_rsp_data%0d", k),  rsp_data,       ((k - 2) % 2 == 1) ? 64'h1 : M1);
      end
      cyc();
    end
    smp();
    chk("il_drained", 64'(rsp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
